pa_iter: RTL and testbench

- Parametrised, multi-cycle successor of the P-A arithmetic unit.
- Generalises the single-cycle 16-bit ALU slice to WIDTH bits.
- Adds an iterative sequencer for shift-add multiply and multi-bit shifts, using an internal AT-style extension register.
- Sits between the control unit (which issues start/op) and the W-bus / register file; results return as a double-width pair plus flags.

---
 rtl/pa_iter.sv | 219 +++++++++++++++++++++
 tb/tb_pa_iter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pa_iter.sv
// pa_iter: multi-cycle WIDTH-bit arithmetic unit (add/sub/logic, shift-add multiply, iterative shifts).
// Define PA_ITER_SIGNED_MUL_EN to make MUL operate on two's-complement operands.
module pa_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             fl_z,
  output logic             fl_m,
  output logic             fl_c,
  output logic             fl_v
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic             cin_q;
  logic             zero_q;
  logic [CNT_W-1:0] iter;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             accept;
  logic             last;
  logic [CNT_W-1:0] iter_init;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   sum;
  logic             c_msb_in;
  logic [WIDTH:0]   hi_x;
  logic [WIDTH:0]   a_x;
  logic [WIDTH:0]   psum;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic             nxt_z;
  logic             nxt_m;
  logic             nxt_c;
  logic             nxt_v;

  assign busy   = (state == S_EXEC);
  assign done   = (state == S_FIN);
  assign accept = start && (state != S_EXEC);
  assign last   = (iter == CNT_W'(1));

  always_comb begin
    iter_init = CNT_W'(1);
    if (op == OP_MUL) begin
      iter_init = CNT_W'(WIDTH);
    end else if ((op == OP_SHL) || (op == OP_SHR)) begin
      if (cnt == '0)
        iter_init = CNT_W'(1);
      else if (cnt >= CNT_W'(WIDTH))
        iter_init = CNT_W'(WIDTH);
      else
        iter_init = cnt;
    end
  end

  // SUB reuses the adder: a + ~b + cin, so cin=1 means "no borrow in".
  always_comb begin
    add_b    = (op_q == OP_SUB) ? ~lo_q : lo_q;
    sum      = {1'b0, a_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin_q};
    c_msb_in = sum[WIDTH-1] ^ a_q[WIDTH-1] ^ add_b[WIDTH-1];
  end

  // One multiply step on a WIDTH+1 bit partial sum; the extra bit is the AT-style extension.
  always_comb begin
`ifdef PA_ITER_SIGNED_MUL_EN
    hi_x = {hi_q[WIDTH-1], hi_q};
    a_x  = {a_q[WIDTH-1], a_q};
    if (lo_q[0])
      psum = last ? (hi_x - a_x) : (hi_x + a_x);
    else
      psum = hi_x;
`else
    hi_x = {1'b0, hi_q};
    a_x  = {1'b0, a_q};
    psum = lo_q[0] ? (hi_x + a_x) : hi_x;
`endif
  end

  always_comb begin
    nxt_hi = hi_q;
    nxt_lo = lo_q;
    nxt_c  = 1'b0;
    nxt_v  = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        nxt_hi = '0;
        nxt_lo = sum[WIDTH-1:0];
        nxt_c  = sum[WIDTH];
        nxt_v  = c_msb_in ^ sum[WIDTH];
      end
      OP_AND: begin
        nxt_hi = '0;
        nxt_lo = a_q & lo_q;
      end
      OP_OR: begin
        nxt_hi = '0;
        nxt_lo = a_q | lo_q;
      end
      OP_XOR: begin
        nxt_hi = '0;
        nxt_lo = a_q ^ lo_q;
      end
      OP_MUL: begin
        nxt_hi = psum[WIDTH:1];
        nxt_lo = {psum[0], lo_q[WIDTH-1:1]};
`ifdef PA_ITER_SIGNED_MUL_EN
        nxt_v  = (nxt_hi != {WIDTH{nxt_lo[WIDTH-1]}});
`else
        nxt_v  = (nxt_hi != '0);
`endif
      end
      OP_SHL: begin
        if (!zero_q) begin
          nxt_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
          nxt_lo = {lo_q[WIDTH-2:0], 1'b0};
          nxt_c  = lo_q[WIDTH-1];
        end
      end
      default: begin
        if (!zero_q) begin
          nxt_hi = {lo_q[0], hi_q[WIDTH-1:1]};
          nxt_lo = {1'b0, lo_q[WIDTH-1:1]};
          nxt_c  = lo_q[0];
        end
      end
    endcase
  end

  always_comb begin
    nxt_z = 1'b0;
    nxt_m = 1'b0;
    if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
      nxt_z = (nxt_lo == '0);
      nxt_m = nxt_lo[WIDTH-1] ^ nxt_v;
    end else if ((op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR)) begin
      nxt_z = (nxt_lo == '0);
      nxt_m = nxt_lo[WIDTH-1];
    end else begin
      nxt_z = ({nxt_hi, nxt_lo} == '0);
      nxt_m = nxt_hi[WIDTH-1];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      cin_q  <= 1'b0;
      zero_q <= 1'b0;
      iter   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      res_hi <= '0;
      res_lo <= '0;
      fl_z   <= 1'b0;
      fl_m   <= 1'b0;
      fl_c   <= 1'b0;
      fl_v   <= 1'b0;
    end else begin
      if (accept) begin
        state  <= S_EXEC;
        op_q   <= op;
        a_q    <= a;
        cin_q  <= cin;
        zero_q <= (cnt == '0);
        iter   <= iter_init;
        hi_q   <= '0;
        lo_q   <= ((op == OP_SHL) || (op == OP_SHR)) ? a : b;
      end else begin
        case (state)
          S_EXEC: begin
            hi_q <= nxt_hi;
            lo_q <= nxt_lo;
            iter <= iter - CNT_W'(1);
            if (last) begin
              state  <= S_FIN;
              res_hi <= nxt_hi;
              res_lo <= nxt_lo;
              fl_z   <= nxt_z;
              fl_m   <= nxt_m;
              fl_c   <= nxt_c;
              fl_v   <= nxt_v;
            end
          end
          S_FIN:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pa_iter.sv
// Scoreboard bench for pa_iter (WIDTH=16): directed vectors, expected {hi,lo,z,m,c,v} and done cycle queued.
module tb_pa_iter;

  localparam int W  = 16;
  localparam int EW = 2 * W + 4;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, MUL = 3'd5, SHL = 3'd6, SHR = 3'd7;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic [5:0]    cnt = '0;
  logic          busy, done, fl_z, fl_m, fl_c, fl_v;
  logic [W-1:0]  res_hi, res_lo;

  pa_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_sys(clk_sys), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cin(cin), .cnt(cnt), .busy(busy), .done(done), .res_hi(res_hi),
    .res_lo(res_lo), .fl_z(fl_z), .fl_m(fl_m), .fl_c(fl_c), .fl_v(fl_v)
  );

  // ---- clock / reset ----
  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // ---- scoreboard ----
  logic [EW-1:0] exp_q[$];
  int unsigned   cyc_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_got;
  int unsigned   mon_cyc;

  function automatic logic [EW-1:0] pk(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                       input logic z, input logic m, input logic c, input logic v);
    return {hi, lo, z, m, c, v};
  endfunction

  always @(negedge clk_sys) begin
    if (done) begin
      mon_got = {res_hi, res_lo, fl_z, fl_m, fl_c, fl_v};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d: got %h, none expected", cyc, mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = cyc_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL result: got hi/lo/zmcv=%h required %h", mon_got, mon_exp);
        end
        n_chk++;
        if (cyc != mon_cyc) begin
          n_fail++;
          $display("FAIL latency: done at cycle %0d required %0d", cyc, mon_cyc);
        end
      end
    end
  end

  // ---- driver tasks (called positioned just after a negedge) ----
  task automatic issue(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic [5:0] icnt, input logic [EW-1:0] e,
                       input int lat, input bit expect_done);
    op = o; a = ia; b = ib; cin = ic; cnt = icnt; start = 1'b1;
    if (expect_done) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc + lat);
    end
    @(negedge clk_sys);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); cnt = 6'($urandom);
    op = 3'($urandom);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60; i++) begin
      if (done) return;
      @(negedge clk_sys);
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout %s: done=0 after 60 cycles, required 1", name);
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic ic, input logic [5:0] icnt, input logic [EW-1:0] e,
                     input int lat, input string name);
    issue(o, ia, ib, ic, icnt, e, lat, 1'b1);
    wait_done(name);
    @(negedge clk_sys);
  endtask

  task automatic check_reset(input string name);
    n_chk++;
    if ({busy, done, res_hi, res_lo, fl_z, fl_m, fl_c, fl_v} !== '0) begin
      n_fail++;
      $display("FAIL %s: busy=%b done=%b hi=%h lo=%h zmcv=%b%b%b%b required all 0",
               name, busy, done, res_hi, res_lo, fl_z, fl_m, fl_c, fl_v);
    end
  endtask

  task automatic check_busy(input string name, input logic req);
    n_chk++;
    if (busy !== req) begin
      n_fail++;
      $display("FAIL %s: busy=%b required %b", name, busy, req);
    end
  endtask

  // ---- stimulus ----
  initial begin
    repeat (3) @(negedge clk_sys);
    check_reset("reset_state");
    rst = 1'b0;
    @(negedge clk_sys);

    run(ADD, 16'h7FFF, 16'h0001, 1'b0, 6'd0, pk(16'h0000, 16'h8000, 0, 0, 0, 1), 2, "add_ovf");
    run(SUB, 16'h0005, 16'h0005, 1'b1, 6'd0, pk(16'h0000, 16'h0000, 1, 0, 1, 0), 2, "sub_zero");
    run(ADD, 16'hFFFF, 16'h0001, 1'b1, 6'd0, pk(16'h0000, 16'h0001, 0, 0, 1, 0), 2, "add_carry");
    run(SUB, 16'h0000, 16'h0001, 1'b1, 6'd0, pk(16'h0000, 16'hFFFF, 0, 1, 0, 0), 2, "sub_borrow");
    run(SUB, 16'h8000, 16'h0001, 1'b1, 6'd0, pk(16'h0000, 16'h7FFF, 0, 1, 1, 1), 2, "sub_ovf");
    run(AND_, 16'hF0F0, 16'hFF00, 1'b1, 6'd0, pk(16'h0000, 16'hF000, 0, 1, 0, 0), 2, "and");
    run(OR_, 16'h0000, 16'h0000, 1'b1, 6'd0, pk(16'h0000, 16'h0000, 1, 0, 0, 0), 2, "or_zero");
    run(XOR_, 16'hA5A5, 16'h5A5A, 1'b0, 6'd0, pk(16'h0000, 16'hFFFF, 0, 1, 0, 0), 2, "xor");
`ifdef PA_ITER_SIGNED_MUL_EN
    run(MUL, 16'hFFFF, 16'hFFFF, 1'b0, 6'd0, pk(16'h0000, 16'h0001, 0, 0, 0, 0), 17, "mul_ff");
    run(MUL, 16'h8000, 16'h0002, 1'b0, 6'd0, pk(16'hFFFF, 16'h0000, 0, 1, 0, 1), 17, "mul_hi");
`else
    run(MUL, 16'hFFFF, 16'hFFFF, 1'b0, 6'd0, pk(16'hFFFE, 16'h0001, 0, 1, 0, 1), 17, "mul_ff");
    run(MUL, 16'h8000, 16'h0002, 1'b0, 6'd0, pk(16'h0001, 16'h0000, 0, 0, 0, 1), 17, "mul_hi");
`endif
    run(SHL, 16'h8001, 16'h0000, 1'b0, 6'd3, pk(16'h0004, 16'h0008, 0, 0, 0, 0), 4, "shl3");
    run(SHR, 16'h0006, 16'h0000, 1'b0, 6'd2, pk(16'h8000, 16'h0001, 0, 1, 1, 0), 3, "shr2");
    run(SHL, 16'h1234, 16'h0000, 1'b1, 6'd0, pk(16'h0000, 16'h1234, 0, 0, 0, 0), 2, "shl0");
    run(SHL, 16'hABCD, 16'h0000, 1'b0, 6'd20, pk(16'hABCD, 16'h0000, 0, 1, 1, 0), 17, "shl_sat");
    run(SHR, 16'hABCD, 16'h0000, 1'b0, 6'd16, pk(16'hABCD, 16'h0000, 0, 1, 1, 0), 17, "shr_sat");

    // start pulsed while a multiply is running must be ignored
    issue(MUL, 16'h0003, 16'h0005, 1'b0, 6'd0, pk(16'h0000, 16'h000F, 0, 0, 0, 0), 17, 1'b1);
    repeat (4) @(negedge clk_sys);
    op = ADD; a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    check_busy("busy_during_mul", 1'b1);
    wait_done("mul_ignore");
    @(negedge clk_sys);

    // reset mid-multiply: abort with no done pulse
    issue(MUL, 16'hFFFF, 16'h0002, 1'b0, 6'd0, '0, 0, 1'b0);
    repeat (4) @(negedge clk_sys);
    op = ADD; a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    check_reset("reset_abort");
    rst = 1'b0;
    repeat (20) @(negedge clk_sys);

    // back-to-back: second start in the done cycle
    issue(ADD, 16'h1234, 16'h1111, 1'b1, 6'd0, pk(16'h0000, 16'h2346, 0, 0, 0, 0), 2, 1'b1);
    wait_done("b2b_first");
    issue(SUB, 16'h0010, 16'h0020, 1'b1, 6'd0, pk(16'h0000, 16'hFFF0, 0, 1, 0, 0), 2, 1'b1);
    check_busy("b2b_busy", 1'b1);
    wait_done("b2b_second");
    repeat (3) @(negedge clk_sys);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
